scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_pkg.sv | 17 +
 rtl/next_row_finder.sv | 25 ++
 rtl/scan_sequencer.sv | 123 ++++++++++++
 tb/tb_scan_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the row scan sequencer.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   // The blank and dwell phases share one down-counter, sized for the longer of the two.
   function automatic int cnt_width(input int dwell, input int blank);
      int m;
      m = (dwell > blank) ? dwell : blank;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/next_row_finder.sv
// Finds the next enabled row strictly above cur_sel, wrapping around, and flags the wrap.
module next_row_finder #(
   parameter  int WIDTH     = 16,
   localparam int ADDR_SIZE = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0]     row_mask,
   input  logic [ADDR_SIZE-1:0] cur_sel,
   output logic [ADDR_SIZE-1:0] next_sel,
   output logic                 wrap
);

   // Walk the rotated mask from the top down so the lowest rotated hit wins.
   always_comb begin
      int j;
      j        = 0;
      next_sel = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         j = int'(cur_sel) + 1 + i;
         if (j >= WIDTH) j = j - WIDTH;
         if (row_mask[j]) next_sel = ADDR_SIZE'(j);
      end
      wrap = (next_sel <= cur_sel);
   end

endmodule

// File: rtl/scan_sequencer.sv
// Steps a row decoder through the enabled rows with a blank gap before each dwell.
//  state  | meaning
//  IDLE   | not scanning, sel parked at 0
//  BLANK  | new row selected, enable held low
//  ACTIVE | enable high for the row dwell
module scan_sequencer
   import scan_pkg::*;
#(
   parameter  int WIDTH        = 16,
   parameter  int DWELL_CYCLES = 8,
   parameter  int BLANK_CYCLES = 2,
   localparam int ADDR_SIZE    = $clog2(WIDTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [WIDTH-1:0]     row_mask,
   output logic [ADDR_SIZE-1:0] sel,
   output logic                 enable,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int          CW       = cnt_width(DWELL_CYCLES, BLANK_CYCLES);
   localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL_CYCLES - 1);

   state_e                state_q, state_d;
   logic [ADDR_SIZE-1:0]  sel_q, sel_d;
   logic                  enable_q, enable_d;
   logic                  frame_done_q, frame_done_d;
   logic                  busy_q, busy_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic [ADDR_SIZE-1:0]  finder_cur;
   logic [ADDR_SIZE-1:0]  nxt_sel;
   logic                  nxt_wrap;

   // From IDLE, searching above the top row yields the lowest set bit.
   assign finder_cur = (state_q == IDLE) ? ADDR_SIZE'(WIDTH - 1) : sel_q;

   next_row_finder #(.WIDTH(WIDTH)) u_finder (
      .row_mask (row_mask),
      .cur_sel  (finder_cur),
      .next_sel (nxt_sel),
      .wrap     (nxt_wrap)
   );

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      enable_d     = enable_q;
      frame_done_d = 1'b0;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            enable_d = 1'b0;
            if (run && (|row_mask)) begin
               state_d = BLANK;
               sel_d   = nxt_sel;
               cnt_d   = BLANK_LD;
            end
         end
         BLANK: begin
            if (cnt_q == '0) begin
               state_d  = ACTIVE;
               enable_d = 1'b1;
               cnt_d    = DWELL_LD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACTIVE: begin
            if (cnt_q == '0) begin
               enable_d = 1'b0;
               if (run && (|row_mask)) begin
                  state_d      = BLANK;
                  sel_d        = nxt_sel;
                  frame_done_d = nxt_wrap;
                  cnt_d        = BLANK_LD;
               end else begin
                  state_d = IDLE;
                  sel_d   = '0;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: begin
            state_d  = IDLE;
            sel_d    = '0;
            enable_d = 1'b0;
            cnt_d    = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         sel_q        <= '0;
         enable_q     <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         enable_q     <= enable_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
      end
   end

   assign sel        = sel_q;
   assign enable     = enable_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with WIDTH=4, DWELL_CYCLES=3, BLANK_CYCLES=1.
module tb_scan_sequencer;

   logic       clk;
   logic       reset;
   logic       run;
   logic [3:0] row_mask;
   logic [1:0] sel;
   logic       enable;
   logic       frame_done;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       run;
      logic [3:0] mask;
      logic [1:0] sel;
      logic       en;
      logic       fd;
      logic       busy;
   } vec_t;

   vec_t vecs[$];

   scan_sequencer #(.WIDTH(4), .DWELL_CYCLES(3), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .row_mask   (row_mask),
      .sel        (sel),
      .enable     (enable),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] m, input logic [1:0] s,
                      input logic e, input logic f, input logic b);
      vec_t v;
      v.run = r; v.mask = m; v.sel = s; v.en = e; v.fd = f; v.busy = b;
      vecs.push_back(v);
   endtask

   task automatic check_outputs(input string tag, input logic [1:0] s, input logic e,
                                input logic f, input logic b);
      chk({tag, " sel"}, int'(sel), int'(s));
      chk({tag, " enable"}, int'(enable), int'(e));
      chk({tag, " frame_done"}, int'(frame_done), int'(f));
      chk({tag, " busy"}, int'(busy), int'(b));
   endtask

   task automatic add_active(input logic r, input logic [3:0] m, input logic [1:0] s, input int n);
      for (int i = 0; i < n; i++) add(r, m, s, 1'b1, 1'b0, 1'b1);
   endtask

   initial begin
      reset    = 1'b0;
      run      = 1'b0;
      row_mask = 4'b0000;
      #2;
      check_outputs("reset", 2'd0, 1'b0, 1'b0, 1'b0);
      #10;
      reset = 1'b1;

      // Full mask: 0,1,2,3 then wrap to 0 with frame_done; run dropped in row 0's dwell.
      add(1, 4'b1111, 0, 0, 0, 1);
      add_active(1, 4'b1111, 0, 3);
      add(1, 4'b1111, 1, 0, 0, 1);
      add_active(1, 4'b1111, 1, 3);
      add(1, 4'b1111, 2, 0, 0, 1);
      add_active(1, 4'b1111, 2, 3);
      add(1, 4'b1111, 3, 0, 0, 1);
      add_active(1, 4'b1111, 3, 3);
      add(1, 4'b1111, 0, 0, 1, 1);
      add(1, 4'b1111, 0, 1, 0, 1);
      add_active(0, 4'b1111, 0, 2);
      add(0, 4'b1111, 0, 0, 0, 0);
      add(0, 4'b1111, 0, 0, 0, 0);

      // Sparse mask alternates rows 1 and 3.
      add(1, 4'b1010, 1, 0, 0, 1);
      add_active(1, 4'b1010, 1, 3);
      add(1, 4'b1010, 3, 0, 0, 1);
      add_active(1, 4'b1010, 3, 3);
      add(1, 4'b1010, 1, 0, 1, 1);
      add(1, 4'b1010, 1, 1, 0, 1);
      add_active(0, 4'b1010, 1, 2);
      add(0, 4'b1010, 0, 0, 0, 0);

      // Single row: frame_done every row period.
      add(1, 4'b0100, 2, 0, 0, 1);
      add_active(1, 4'b0100, 2, 3);
      add(1, 4'b0100, 2, 0, 1, 1);
      add_active(1, 4'b0100, 2, 3);
      add(1, 4'b0100, 2, 0, 1, 1);
      add(1, 4'b0100, 2, 1, 0, 1);
      add_active(0, 4'b0100, 2, 2);
      add(0, 4'b0100, 0, 0, 0, 0);

      // run dropped during the 2nd dwell cycle of row 1.
      add(1, 4'b1111, 0, 0, 0, 1);
      add_active(1, 4'b1111, 0, 3);
      add(1, 4'b1111, 1, 0, 0, 1);
      add_active(1, 4'b1111, 1, 2);
      add(0, 4'b1111, 1, 1, 0, 1);
      add(0, 4'b1111, 0, 0, 0, 0);

      // Mask cleared mid-dwell: row finishes, then IDLE even with run held.
      add(1, 4'b1111, 0, 0, 0, 1);
      add(1, 4'b1111, 0, 1, 0, 1);
      add_active(1, 4'b0000, 0, 2);
      add(1, 4'b0000, 0, 0, 0, 0);
      add(1, 4'b0000, 0, 0, 0, 0);
      add(1, 4'b0000, 0, 0, 0, 0);
      add(0, 4'b0000, 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         run      = vecs[i].run;
         row_mask = vecs[i].mask;
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].en, vecs[i].fd, vecs[i].busy);
      end

      // Asynchronous reset in the middle of a dwell.
      run      = 1'b1;
      row_mask = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      chk("pre_reset enable", int'(enable), 1);
      #3;
      reset = 1'b0;
      #1;
      check_outputs("async_reset", 2'd0, 1'b0, 1'b0, 1'b0);
      run = 1'b0;
      #10;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("post_reset_idle", 2'd0, 1'b0, 1'b0, 1'b0);
      run      = 1'b1;
      row_mask = 4'b0010;
      @(posedge clk);
      #1;
      check_outputs("restart_blank", 2'd1, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_outputs("restart_active", 2'd1, 1'b1, 1'b0, 1'b1);

      // Mask held steady: count frame_done pulses over a bounded window.
      begin
         int pulses;
         pulses = 0;
         for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (frame_done) pulses++;
         end
         chk("fd_pulse_count", pulses, 5);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
